// File: rtl/uart_msg_sequencer_pkg.sv
// rtl/uart_msg_sequencer_pkg.sv - shared types and widths for the UART message sequencer
// Contents:
//   MSG_W        message register width (bits)
//   BYTE_W       transmitter byte width (bits)
//   LEN_W        byte-count field width (bits)
//   seq_state_t  sequencer FSM state encoding
package uart_msg_sequencer_pkg;

    localparam int MSG_W  = 32;
    localparam int BYTE_W = 8;
    localparam int LEN_W  = 2;

    // ST_RECOVER is the single cycle that follows an abort or an ack timeout;
    // the transmitter is disabled there so it drops any partial frame.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5,
        ST_RECOVER = 3'd6
    } seq_state_t;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for slow-changing level signals
// Ports:
//   clk    destination clock
//   reset  asynchronous active-low reset, flops clear to 0
//   d      asynchronous input level(s)
//   q      synchronized output level(s), two clk cycles of latency
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_msg_sequencer.sv
// rtl/uart_msg_sequencer.sv - sends a 1..4 byte message to a UART transmitter with a WR/BUSY handshake
// Optional feature macro: SEQ_ACK_TIMEOUT_EN (per-phase ack timeout, sets error and aborts)
// Ports:
//   clk, reset            system clock, asynchronous active-low reset
//   start, abort          message request (taken in IDLE only) / cancel in-flight message
//   msg_data, msg_len     message bytes (byte 0 in [7:0] goes first), byte count minus one
//   ready, done, error    idle indicator, end-of-message pulse, sticky timeout flag
//   Tx_EN, Tx_WR, Tx_DATA transmitter enable, write strobe, byte
//   Tx_BUSY               transmitter busy, asynchronous to clk
module uart_msg_sequencer
    import uart_msg_sequencer_pkg::*;
#(
    parameter int ACK_TIMEOUT = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [MSG_W-1:0]  msg_data,
    input  logic [LEN_W-1:0]  msg_len,
    output logic              ready,
    output logic              done,
    output logic              error,
    output logic              Tx_EN,
    output logic              Tx_WR,
    output logic [BYTE_W-1:0] Tx_DATA,
    input  logic              Tx_BUSY
);

    seq_state_t        state;
    seq_state_t        next_state;
    logic              busy_s;
    logic [MSG_W-1:0]  shift_q;
    logic [LEN_W-1:0]  byte_cnt_q;
    logic [BYTE_W-1:0] tx_data_q;
    logic              timeout_hit;
    logic              in_wait;

    sync_2ff #(
        .WIDTH (1)
    ) u_busy_sync (
        .clk   (clk),
        .reset (reset),
        .d     (Tx_BUSY),
        .q     (busy_s)
    );

    assign in_wait = (state == ST_WRITE) || (state == ST_DRAIN);

`ifdef SEQ_ACK_TIMEOUT_EN
    localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

    logic [TW-1:0] ack_cnt_q;
    logic          error_q;
    logic          wait_entry;

    // WRITE->DRAIN is also an entry, so each handshake phase gets its own budget.
    assign wait_entry = (next_state != state) &&
                        ((next_state == ST_WRITE) || (next_state == ST_DRAIN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack_cnt_q <= '0;
        end else if (wait_entry) begin
            ack_cnt_q <= '0;
        end else if (in_wait) begin
            ack_cnt_q <= ack_cnt_q + 1'b1;
        end
    end

    // Counter reads k during the k-th cycle of the phase, so the recovery
    // cycle starts exactly ACK_TIMEOUT cycles after phase entry.
    assign timeout_hit = in_wait && (ack_cnt_q == TW'(ACK_TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            error_q <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            error_q <= 1'b0;
        end else if (timeout_hit) begin
            error_q <= 1'b1;
        end
    end

    assign error = error_q;
`else
    logic [31:0] unused_ack_timeout;

    assign unused_ack_timeout = 32'(ACK_TIMEOUT);
    assign timeout_hit        = 1'b0;
    assign error              = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        ready      = 1'b0;
        done       = 1'b0;
        Tx_EN      = 1'b1;
        Tx_WR      = 1'b0;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort) begin
                    next_state = ST_RECOVER;
                end else begin
                    next_state = ST_WRITE;
                end
            end
            ST_WRITE: begin
                Tx_WR = 1'b1;
                if (abort || timeout_hit) begin
                    next_state = ST_RECOVER;
                end else if (busy_s) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (abort || timeout_hit) begin
                    next_state = ST_RECOVER;
                end else if (!busy_s) begin
                    next_state = ST_NEXT;
                end
            end
            ST_NEXT: begin
                if (abort) begin
                    next_state = ST_RECOVER;
                end else if (byte_cnt_q == '0) begin
                    next_state = ST_DONE;
                end else begin
                    next_state = ST_LOAD;
                end
            end
            ST_DONE: begin
                // abort here is deliberately ignored: the message is complete
                done       = 1'b1;
                next_state = ST_IDLE;
            end
            ST_RECOVER: begin
                Tx_EN      = 1'b0;
                next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Message datapath. Tx_DATA is only reloaded on LOAD->WRITE, which the
    // FSM reaches only after busy_s has been seen low with Tx_WR low.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q    <= '0;
            byte_cnt_q <= '0;
            tx_data_q  <= '0;
        end else begin
            if ((state == ST_IDLE) && start) begin
                shift_q    <= msg_data;
                byte_cnt_q <= msg_len;
            end
            if ((state == ST_LOAD) && (next_state == ST_WRITE)) begin
                tx_data_q <= shift_q[BYTE_W-1:0];
            end
            if ((state == ST_NEXT) && (next_state == ST_LOAD)) begin
                shift_q    <= shift_q >> BYTE_W;
                byte_cnt_q <= byte_cnt_q - 1'b1;
            end
        end
    end

    assign Tx_DATA = tx_data_q;

endmodule

// File: tb/tb_uart_msg_sequencer.sv
// tb/tb_uart_msg_sequencer.sv - directed self-checking bench for uart_msg_sequencer
module tb_uart_msg_sequencer;

`ifdef SEQ_ACK_TIMEOUT_EN
    localparam int TB_TIMEOUT = 16;
`else
    localparam int TB_TIMEOUT = 1023;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic        abort;
    logic [31:0] msg_data;
    logic [1:0]  msg_len;
    logic        ready;
    logic        done;
    logic        error;
    logic        Tx_EN;
    logic        Tx_WR;
    logic [7:0]  Tx_DATA;
    logic        Tx_BUSY;

    int total;
    int passed;
    int done_cnt;
    int wr_rise_cnt;
    int en_low_cnt;
    int stab_viol;
    int en_low_exp;

    logic       prev_wr;
    logic       prev_busy;
    logic [7:0] prev_data;

    uart_msg_sequencer #(
        .ACK_TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .msg_data (msg_data),
        .msg_len  (msg_len),
        .ready    (ready),
        .done     (done),
        .error    (error),
        .Tx_EN    (Tx_EN),
        .Tx_WR    (Tx_WR),
        .Tx_DATA  (Tx_DATA),
        .Tx_BUSY  (Tx_BUSY)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Passive monitor: pulse/edge counters and Tx_DATA stability while WR or BUSY.
    initial begin
        done_cnt    = 0;
        wr_rise_cnt = 0;
        en_low_cnt  = 0;
        stab_viol   = 0;
        prev_wr     = 1'b0;
        prev_busy   = 1'b0;
        prev_data   = 8'h00;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_wr   = 1'b0;
                prev_busy = 1'b0;
                prev_data = Tx_DATA;
            end else begin
                if (done) done_cnt++;
                if (Tx_WR && !prev_wr) wr_rise_cnt++;
                if (!Tx_EN) en_low_cnt++;
                if ((prev_wr || prev_busy) && (Tx_DATA !== prev_data)) stab_viol++;
                prev_wr   = Tx_WR;
                prev_busy = Tx_BUSY;
                prev_data = Tx_DATA;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_wr(input logic level, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (Tx_WR === level) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Transmitter model for one byte: take the strobe, go busy, hold busy a while.
    task automatic xmit_byte(input string tag, input logic [7:0] exp, input int hold);
        bit ok;
        wait_wr(1'b1, ok);
        check({tag, "_wr_seen"}, 32'(ok), 32'd1);
        check({tag, "_data"}, 32'(Tx_DATA), 32'(exp));
        repeat (2) @(negedge clk);
        Tx_BUSY = 1'b1;
        wait_wr(1'b0, ok);
        check({tag, "_wr_drop"}, 32'(ok), 32'd1);
        repeat (hold) @(negedge clk);
        Tx_BUSY = 1'b0;
    endtask

    task automatic send(input logic [31:0] data, input logic [1:0] len);
        msg_data = data;
        msg_len  = len;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        msg_data = 32'hFFFF_FFFF;
        msg_len  = 2'd3;
    endtask

    initial begin
        bit ok;
        int d0;
        int w0;
        int n;

        total      = 0;
        passed     = 0;
        en_low_exp = 0;
        reset      = 1'b0;
        start      = 1'b0;
        abort      = 1'b0;
        msg_data   = 32'h0;
        msg_len    = 2'd0;
        Tx_BUSY    = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_en", 32'(Tx_EN), 32'd1);
        check("rst_wr", 32'(Tx_WR), 32'd0);
        check("rst_data", 32'(Tx_DATA), 32'h00);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Four-byte message; a stray start mid-message must be ignored
        d0 = done_cnt;
        w0 = wr_rise_cnt;
        send(32'hA1B2C3D4, 2'd3);
        check("a_ready_busy", 32'(ready), 32'd0);
        xmit_byte("a_b0", 8'hD4, 3);
        msg_data = 32'h5A5A5A5A;
        msg_len  = 2'd0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        xmit_byte("a_b1", 8'hC3, 2);
        xmit_byte("a_b2", 8'hB2, 4);
        xmit_byte("a_b3", 8'hA1, 1);
        wait_ready(ok);
        check("a_ready_back", 32'(ok), 32'd1);
        repeat (8) @(negedge clk);
        check("a_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("a_wr_cnt", 32'(wr_rise_cnt - w0), 32'd4);
        check("a_wr_idle", 32'(Tx_WR), 32'd0);

        // One-byte message
        d0 = done_cnt;
        w0 = wr_rise_cnt;
        send(32'h12345655, 2'd0);
        xmit_byte("b_b0", 8'h55, 2);
        wait_ready(ok);
        check("b_ready_back", 32'(ok), 32'd1);
        repeat (4) @(negedge clk);
        check("b_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("b_wr_cnt", 32'(wr_rise_cnt - w0), 32'd1);

        // Abort during DRAIN of byte 2
        d0 = done_cnt;
        w0 = wr_rise_cnt;
        n  = en_low_cnt;
        send(32'h11223344, 2'd3);
        xmit_byte("c_b0", 8'h44, 2);
        wait_wr(1'b1, ok);
        check("c_b1_data", 32'(Tx_DATA), 32'h33);
        repeat (2) @(negedge clk);
        Tx_BUSY = 1'b1;
        wait_wr(1'b0, ok);
        check("c_in_drain", 32'(ok), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("c_en_low", 32'(Tx_EN), 32'd0);
        check("c_wr_low", 32'(Tx_WR), 32'd0);
        check("c_ready_low", 32'(ready), 32'd0);
        @(negedge clk);
        check("c_en_back", 32'(Tx_EN), 32'd1);
        check("c_ready_next", 32'(ready), 32'd1);
        Tx_BUSY = 1'b0;
        en_low_exp++;
        repeat (6) @(negedge clk);
        check("c_no_done", 32'(done_cnt - d0), 32'd0);
        check("c_en_low_cycles", 32'(en_low_cnt - n), 32'd1);
        check("c_wr_cnt", 32'(wr_rise_cnt - w0), 32'd2);
        check("c_error", 32'(error), 32'd0);

        // Reset during WRITE
        d0 = done_cnt;
        send(32'h0000AABB, 2'd1);
        wait_wr(1'b1, ok);
        check("d_in_write", 32'(ok), 32'd1);
        reset = 1'b0;
        #1;
        check("d_rst_ready", 32'(ready), 32'd1);
        check("d_rst_wr", 32'(Tx_WR), 32'd0);
        check("d_rst_data", 32'(Tx_DATA), 32'h00);
        check("d_rst_en", 32'(Tx_EN), 32'd1);
        check("d_rst_done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("d_no_done", 32'(done_cnt - d0), 32'd0);
        check("d_wr_idle", 32'(Tx_WR), 32'd0);

`ifdef SEQ_ACK_TIMEOUT_EN
        // Ack timeout with Tx_BUSY stuck low
        send(32'h000000C7, 2'd0);
        wait_wr(1'b1, ok);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (Tx_EN === 1'b0) break;
            @(negedge clk);
            n++;
        end
        check("e_timeout_cycles", 32'(n), 32'd16);
        check("e_error_set", 32'(error), 32'd1);
        en_low_exp++;
        @(negedge clk);
        check("e_ready", 32'(ready), 32'd1);
        check("e_error_sticky", 32'(error), 32'd1);
        send(32'h0000003C, 2'd0);
        check("e_error_clear", 32'(error), 32'd0);
        xmit_byte("e_b0", 8'h3C, 2);
        wait_ready(ok);
        check("e_ready_back", 32'(ok), 32'd1);
`endif

        repeat (4) @(negedge clk);
        check("stability", 32'(stab_viol), 32'd0);
        check("en_low_total", 32'(en_low_cnt), 32'(en_low_exp));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
